dcache_data_array: RTL



---
 rtl/dcache_data_array.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/dcache_data_array.sv
// dcache_data_array: single-way L1 data SRAM behind the data-array arbiter.
// Byte-masked writes, 1-cycle reads, tagged ready/valid response FIFO with
// bypass. Optional per-byte even parity under DCACHE_DATA_ARRAY_PARITY_EN.
module dcache_data_array #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 64,
    parameter int TAG_W      = 2,
    parameter int RESP_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  io_req_ready,
    input  logic                  io_req_valid,
    input  logic [ADDR_W-1:0]     io_req_bits_addr,
    input  logic                  io_req_bits_write,
    input  logic [DATA_W-1:0]     io_req_bits_wdata,
    input  logic [DATA_W/8-1:0]   io_req_bits_wmask,
    input  logic                  io_req_bits_way_en,
    input  logic [TAG_W-1:0]      io_req_tag,
    input  logic                  io_resp_ready,
    output logic                  io_resp_valid,
    output logic [DATA_W-1:0]     io_resp_bits_data,
    output logic [TAG_W-1:0]      io_resp_bits_tag
`ifdef DCACHE_DATA_ARRAY_PARITY_EN
   ,output logic [DATA_W/8-1:0]   io_resp_bits_perr
`endif
);
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = ADDR_W - 3;
    localparam int DEPTH = 1 << IDX_W;
    localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0] idx;
    logic             fire, wr_fire, rd_fire;
    logic             unused_addr_lsb;

    // In-flight read slot: SRAM output register plus its tag.
    logic              ifl_vld;
    logic [DATA_W-1:0] ifl_data;
    logic [TAG_W-1:0]  ifl_tag;

    // Response FIFO, in order; head is presented when non-empty.
    logic [DATA_W-1:0] fifo_data [RESP_DEPTH];
    logic [TAG_W-1:0]  fifo_tag  [RESP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    occ;
    logic              fifo_ne, pop, push, fifo_pop;

    assign idx             = io_req_bits_addr[ADDR_W-1:3];
    assign unused_addr_lsb = ^io_req_bits_addr[2:0];
    assign fire            = io_req_valid & io_req_ready;
    assign wr_fire         = fire & io_req_bits_write & io_req_bits_way_en;
    assign rd_fire         = fire & ~io_req_bits_write;

    // Credits: reads in flight plus buffered responses; registered state only.
    assign occ          = {1'b0, count} + (CNT_W+1)'(ifl_vld);
    assign io_req_ready = occ < (CNT_W+1)'(RESP_DEPTH);

    // The in-flight slot sits logically behind the FIFO contents; when the FIFO
    // is empty it is presented directly and only enters the FIFO if not taken.
    assign fifo_ne       = count != '0;
    assign io_resp_valid = fifo_ne | ifl_vld;
    assign pop           = io_resp_valid & io_resp_ready;
    assign fifo_pop      = pop & fifo_ne;
    assign push          = ifl_vld & ~(pop & ~fifo_ne);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Byte-masked array write; array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_fire)
            for (int b = 0; b < NB; b++)
                if (io_req_bits_wmask[b]) mem[idx][8*b +: 8] <= io_req_bits_wdata[8*b +: 8];
    end

    // SRAM read register and in-flight tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ifl_vld  <= 1'b0;
            ifl_data <= '0;
            ifl_tag  <= '0;
        end else begin
            ifl_vld <= rd_fire;
            if (rd_fire) begin
                ifl_data <= mem[idx];
                ifl_tag  <= io_req_tag;
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)     wr_ptr <= ptr_inc(wr_ptr);
            if (fifo_pop) rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(fifo_pop);
        end
    end

    // FIFO storage; valid qualification comes from count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= ifl_data;
            fifo_tag[wr_ptr]  <= ifl_tag;
        end
    end

    // Response mux: FIFO head first, else bypass; zero when idle.
    always_comb begin
        io_resp_bits_data = '0;
        io_resp_bits_tag  = '0;
        if (fifo_ne) begin
            io_resp_bits_data = fifo_data[rd_ptr];
            io_resp_bits_tag  = fifo_tag[rd_ptr];
        end else if (ifl_vld) begin
            io_resp_bits_data = ifl_data;
            io_resp_bits_tag  = ifl_tag;
        end
    end

`ifdef DCACHE_DATA_ARRAY_PARITY_EN
    logic [NB-1:0] par_mem  [DEPTH];
    logic [NB-1:0] fifo_perr [RESP_DEPTH];
    logic [NB-1:0] ifl_par, ifl_perr;

    // Even parity per written byte; unwritten bytes keep their old parity.
    always_ff @(posedge clk) begin
        if (wr_fire)
            for (int b = 0; b < NB; b++)
                if (io_req_bits_wmask[b]) par_mem[idx][b] <= ^io_req_bits_wdata[8*b +: 8];
    end

    // Stored parity travels with the read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        ifl_par <= '0;
        else if (rd_fire) ifl_par <= par_mem[idx];
    end

    // Per-byte mismatch between recomputed and stored parity.
    always_comb begin
        ifl_perr = '0;
        for (int b = 0; b < NB; b++) ifl_perr[b] = (^ifl_data[8*b +: 8]) ^ ifl_par[b];
    end

    // Error flags buffered alongside data.
    always_ff @(posedge clk) begin
        if (push) fifo_perr[wr_ptr] <= ifl_perr;
    end

    // Error flag mux, same selection as data.
    always_comb begin
        io_resp_bits_perr = '0;
        if (fifo_ne)      io_resp_bits_perr = fifo_perr[rd_ptr];
        else if (ifl_vld) io_resp_bits_perr = ifl_perr;
    end
`endif

endmodule
